// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB master: FSM encoding, default device IDs
// and the bit/byte counter limits.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DEV_WR_ID    = 8'h42;
  localparam logic [7:0] DEV_RD_ID    = 8'h43;
  localparam logic [3:0] BIT_LAST     = 4'd8;  // index of the 9th (ACK/NA) bit
  localparam logic [1:0] BYTE_LAST_WR = 2'd2;
  localparam logic [1:0] BYTE_LAST_RD = 2'd1;
  localparam int         QUARTERS     = 4;

endpackage

// File: rtl/sccb_bit_timer.sv
// SCCB bit-period divider. Strobes fire in the last clk before the named
// quarter so that registered bus outputs change exactly on the quarter boundary.
module sccb_bit_timer
  import sccb_pkg::*;
#(
  parameter int SCL_DIV = 500
)(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic end_period
);

  localparam int QTR = SCL_DIV / QUARTERS;
  localparam int CW  = $clog2(SCL_DIV);

  logic [CW-1:0] div_cnt;

  // period counter, held at zero while the master is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!run) begin
      div_cnt <= '0;
    end else if (end_period) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign q1         = run && (div_cnt == CW'(QTR - 1));
  assign q2         = run && (div_cnt == CW'(2 * QTR - 1));
  assign q3         = run && (div_cnt == CW'(3 * QTR - 1));
  assign end_period = run && (div_cnt == CW'(SCL_DIV - 1));

endmodule

// File: rtl/sccb_master.sv
// SCCB (OV7670) bus master: serialises one register write or two-phase read
// per request onto SIO_C/SIO_D, all bus outputs registered.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                SCL_DIV = 500,
  parameter logic [DATA_W-1:0] DEV_WR  = DATA_W'(DEV_WR_ID),
  parameter logic [DATA_W-1:0] DEV_RD  = DATA_W'(DEV_RD_ID)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              sio_c,
  output logic              sio_d_out,
  output logic              sio_d_oe,
  input  logic              sio_d_in
);

  state_t            state, state_nx;
  logic [3:0]        bit_cnt, bit_cnt_nx;
  logic [1:0]        byte_idx, byte_idx_nx, last_byte;
  logic [DATA_W-1:0] tx_sh, tx_sh_nx, rx_sh, rx_sh_nx;
  logic [DATA_W-1:0] addr_r, addr_nx, wdata_r, wdata_nx, rdata_nx;
  logic [DATA_W-1:0] first_byte, next_byte;
  logic              is_read, is_read_nx, phase2, phase2_nx, rx_byte;
  logic              sio_c_nx, sio_d_nx, sio_oe_nx, rdata_vld_nx;
  logic              q1, q2, q3, end_period;

  function automatic logic [DATA_W-1:0] byte_sel(input logic ph2, input logic [1:0] idx,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] b;
    if (ph2) begin
      b = DEV_RD;
    end else begin
      case (idx)
        2'd0:    b = DEV_WR;
        2'd1:    b = a;
        default: b = d;
      endcase
    end
    return b;
  endfunction

  sccb_bit_timer #(.SCL_DIV(SCL_DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state != ST_IDLE),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .end_period (end_period)
  );

  // next-state, bus waveform and datapath decode
  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    byte_idx_nx  = byte_idx;
    tx_sh_nx     = tx_sh;
    rx_sh_nx     = rx_sh;
    addr_nx      = addr_r;
    wdata_nx     = wdata_r;
    is_read_nx   = is_read;
    phase2_nx    = phase2;
    sio_c_nx     = sio_c;
    sio_d_nx     = sio_d_out;
    sio_oe_nx    = sio_d_oe;
    rdata_nx     = rdata;
    rdata_vld_nx = 1'b0;
    first_byte   = byte_sel(phase2, 2'd0, addr_r, wdata_r);
    next_byte    = byte_sel(phase2, byte_idx + 2'd1, addr_r, wdata_r);
    last_byte    = (phase2 || is_read) ? BYTE_LAST_RD : BYTE_LAST_WR;
    rx_byte      = phase2 && (byte_idx == 2'd1);
    case (state)
      ST_IDLE: begin
        sio_c_nx  = 1'b1;
        sio_d_nx  = 1'b1;
        if (wr_en || rd_en) begin
          state_nx    = ST_START;
          is_read_nx  = ~wr_en;  // a simultaneous write wins
          phase2_nx   = 1'b0;
          addr_nx     = addr;
          wdata_nx    = wdata;
          bit_cnt_nx  = 4'd0;
          byte_idx_nx = 2'd0;
          sio_oe_nx   = 1'b1;
        end else begin
          sio_oe_nx   = 1'b0;
        end
      end
      ST_START: begin
        if (q2) begin
          sio_d_nx = 1'b0;
        end else if (end_period) begin
          state_nx    = ST_BYTE;
          bit_cnt_nx  = 4'd0;
          byte_idx_nx = 2'd0;
          sio_c_nx    = 1'b0;
          sio_d_nx    = first_byte[DATA_W-1];
          sio_oe_nx   = 1'b1;
          tx_sh_nx    = {first_byte[DATA_W-2:0], 1'b0};
        end else begin
          state_nx    = ST_START;
        end
      end
      ST_BYTE: begin
        if (q1) begin
          sio_c_nx = 1'b1;
        end else if (q2) begin
          if (rx_byte && (bit_cnt != BIT_LAST)) begin
            rx_sh_nx = {rx_sh[DATA_W-2:0], sio_d_in};
          end else begin
            rx_sh_nx = rx_sh;
          end
        end else if (q3) begin
          sio_c_nx = 1'b0;
        end else if (end_period) begin
          sio_c_nx = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            if (byte_idx == last_byte) begin
              state_nx  = ST_STOP;
              sio_d_nx  = 1'b0;
              sio_oe_nx = 1'b1;
            end else begin
              byte_idx_nx = byte_idx + 2'd1;
              bit_cnt_nx  = 4'd0;
              if (phase2) begin
                sio_d_nx  = 1'b1;
                sio_oe_nx = 1'b0;
              end else begin
                sio_d_nx  = next_byte[DATA_W-1];
                sio_oe_nx = 1'b1;
                tx_sh_nx  = {next_byte[DATA_W-2:0], 1'b0};
              end
            end
          end else if (bit_cnt == BIT_LAST - 4'd1) begin
            // 9th bit: released for ACK, or driven high as NA after read data
            bit_cnt_nx = bit_cnt + 4'd1;
            sio_d_nx   = 1'b1;
            sio_oe_nx  = rx_byte;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
            if (rx_byte) begin
              sio_d_nx  = 1'b1;
              sio_oe_nx = 1'b0;
            end else begin
              sio_d_nx  = tx_sh[DATA_W-1];
              sio_oe_nx = 1'b1;
              tx_sh_nx  = {tx_sh[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          state_nx = ST_BYTE;
        end
      end
      ST_STOP: begin
        if (q1) begin
          sio_c_nx = 1'b1;
        end else if (q2) begin
          sio_d_nx = 1'b1;
        end else if (end_period) begin
          sio_c_nx  = 1'b1;
          sio_d_nx  = 1'b1;
          sio_oe_nx = 1'b0;
          if (is_read && !phase2) begin
            state_nx  = ST_GAP;
            phase2_nx = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            if (is_read) begin
              rdata_nx     = rx_sh;
              rdata_vld_nx = 1'b1;
            end else begin
              rdata_nx     = rdata;
            end
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      ST_GAP: begin
        if (end_period) begin
          state_nx    = ST_START;
          bit_cnt_nx  = 4'd0;
          byte_idx_nx = 2'd0;
          sio_c_nx    = 1'b1;
          sio_d_nx    = 1'b1;
          sio_oe_nx   = 1'b1;
        end else begin
          state_nx    = ST_GAP;
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        sio_c_nx  = 1'b1;
        sio_d_nx  = 1'b1;
        sio_oe_nx = 1'b0;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      byte_idx  <= 2'd0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      is_read   <= 1'b0;
      phase2    <= 1'b0;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b0;
      rdy       <= 1'b1;
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      byte_idx  <= byte_idx_nx;
      tx_sh     <= tx_sh_nx;
      rx_sh     <= rx_sh_nx;
      addr_r    <= addr_nx;
      wdata_r   <= wdata_nx;
      is_read   <= is_read_nx;
      phase2    <= phase2_nx;
      sio_c     <= sio_c_nx;
      sio_d_out <= sio_d_nx;
      sio_d_oe  <= sio_oe_nx;
      rdy       <= (state_nx == ST_IDLE);
      rdata     <= rdata_nx;
      rdata_vld <= rdata_vld_nx;
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master (SCL_DIV=8) with an SCCB slave/bus decoder
// that logs START/STOP/bytes with cycle stamps and returns read data.
module tb_sccb_master;

  localparam int START_T = 256;
  localparam int STOP_T  = 257;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       rdy, rdata_vld, sio_c, sio_d_out, sio_d_oe;
  logic [7:0] rdata;
  logic       bus_d;

  logic       slv_oe = 1'b0, slv_bit = 1'b1;
  logic [7:0] rd_val = 8'h76;

  int         cyc = 0, t0 = 0, checks = 0, errors = 0;
  int         log_q[$], ts_q[$], ack_q[$], exp_q[$];
  int         vld_cnt = 0;
  logic [7:0] vld_data = 8'h00;

  assign bus_d = sio_d_oe ? sio_d_out : (slv_oe ? slv_bit : 1'b1);

  sccb_master #(.DATA_W(8), .SCL_DIV(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdy       (rdy),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .sio_c     (sio_c),
    .sio_d_out (sio_d_out),
    .sio_d_oe  (sio_d_oe),
    .sio_d_in  (bus_d)
  );

  initial forever #5 clk = ~clk;

  // slave model and bus decoder, sampling 1 time unit after each rising clk
  initial begin
    logic       prev_c, prev_d, rd_mode, first;
    logic [8:0] sh;
    int         bitn;
    prev_c = 1'b1; prev_d = 1'b1; rd_mode = 1'b0; first = 1'b0; sh = 9'd0; bitn = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rdata_vld === 1'b1) begin
        vld_cnt++;
        vld_data = rdata;
      end
      if (prev_c && sio_c && prev_d && !bus_d) begin
        log_q.push_back(START_T); ts_q.push_back(cyc);
        bitn = 0; rd_mode = 1'b0; first = 1'b1; slv_oe = 1'b0;
      end else if (prev_c && sio_c && !prev_d && bus_d) begin
        log_q.push_back(STOP_T); ts_q.push_back(cyc);
        bitn = 0; rd_mode = 1'b0; slv_oe = 1'b0;
      end else if (!prev_c && sio_c) begin
        sh = {sh[7:0], bus_d};
        bitn++;
        if (bitn == 9) begin
          log_q.push_back(int'(sh[8:1])); ts_q.push_back(cyc);
          ack_q.push_back(int'(sh[0]));
          if (rd_mode) rd_mode = 1'b0;
          else if (first && sh[8:1] == 8'h43) rd_mode = 1'b1;
          first = 1'b0;
          bitn = 0;
        end
      end else if (prev_c && !sio_c) begin
        slv_oe  = rd_mode && (bitn < 8);
        slv_bit = (bitn < 8) ? rd_val[7 - bitn] : 1'b1;
      end
      prev_c = sio_c;
      prev_d = bus_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_len"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) check($sformatf("%s_ev%0d", tag, i), log_q[base + i], exp_q[i]);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_rdy(input string tag, input int exp_dur);
    int n = 0;
    while (rdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, rdy, 1);
    check({tag, "_dur"}, cyc - t0, exp_dur);
  endtask

  initial begin
    int base, vb, nstop;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_rdata", rdata, 8'h00);
    check("rst_vld", rdata_vld, 0);
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d", sio_d_out, 1);
    check("rst_oe", sio_d_oe, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // plain write
    base = log_q.size(); vb = vld_cnt;
    issue(1'b1, 1'b0, 8'h12, 8'h80);
    check("wr_busy", rdy, 0);
    wait_rdy("wr", 232);
    exp_q = {START_T, 'h42, 'h12, 'h80, STOP_T};
    check_log("wr", base);
    check("wr_vld", vld_cnt - vb, 0);
    check("wr_rdata", rdata, 8'h00);

    // two-phase read
    repeat (5) @(negedge clk);
    base = log_q.size(); vb = vld_cnt;
    issue(1'b0, 1'b1, 8'h0A, 8'h00);
    wait_rdy("rd", 328);
    exp_q = {START_T, 'h42, 'h0A, STOP_T, START_T, 'h43, 'h76, STOP_T};
    check_log("rd", base);
    check("rd_gap", (ts_q.size() > base + 4) ? ts_q[base + 4] - ts_q[base + 3] : -1, 16);
    check("rd_na", (ack_q.size() > 0) ? ack_q[$] : -1, 1);
    check("rd_vld", vld_cnt - vb, 1);
    check("rd_vld_data", vld_data, 8'h76);
    check("rd_rdata", rdata, 8'h76);

    // write and read requested together
    repeat (5) @(negedge clk);
    base = log_q.size(); vb = vld_cnt;
    issue(1'b1, 1'b1, 8'h3D, 8'h03);
    wait_rdy("both", 232);
    exp_q = {START_T, 'h42, 'h3D, 'h03, STOP_T};
    check_log("both", base);
    check("both_vld", vld_cnt - vb, 0);

    // request while busy is dropped
    repeat (5) @(negedge clk);
    base = log_q.size();
    issue(1'b1, 1'b0, 8'h55, 8'hAA);
    repeat (48) @(negedge clk);
    wr_en = 1'b1; addr = 8'h66; wdata = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    wait_rdy("busy", 232);
    repeat (24) @(negedge clk);
    exp_q = {START_T, 'h42, 'h55, 'hAA, STOP_T};
    check_log("busy", base);
    check("busy_idle", rdy, 1);

    // wr_en held across completion: back-to-back writes
    base = log_q.size();
    @(negedge clk);
    wr_en = 1'b1; addr = 8'h01; wdata = 8'h02;
    @(negedge clk);
    t0 = cyc;
    wait_rdy("b2b1", 232);
    @(negedge clk);
    check("b2b_accept", rdy, 0);
    t0 = cyc;
    wr_en = 1'b0;
    wait_rdy("b2b2", 232);
    exp_q = {START_T, 'h42, 'h01, 'h02, STOP_T, START_T, 'h42, 'h01, 'h02, STOP_T};
    check_log("b2b", base);
    check("b2b_gap", (ts_q.size() > base + 5) ? ts_q[base + 5] - ts_q[base + 4] : -1, 9);

    // reset in the middle of the address byte
    repeat (5) @(negedge clk);
    base = log_q.size(); vb = vld_cnt;
    issue(1'b1, 1'b0, 8'h12, 8'h34);
    repeat (102) @(negedge clk);
    check("abort_busy", rdy, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sio_c", sio_c, 1);
    check("abort_oe", sio_d_oe, 0);
    check("abort_rdy", rdy, 1);
    check("abort_vld", rdata_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    nstop = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i] == STOP_T) nstop++;
    check("abort_nostop", nstop, 0);
    check("abort_vld_cnt", vld_cnt - vb, 0);
    check("abort_idle", rdy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
